// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle RV32I controller and the
// datapath / instruction register / memory port.
interface multicycle_control_if;
  logic       run;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       is_branch;
  logic       is_alu_reg;
  logic       is_alu_imm;
  logic       busy;
  logic       trap;
  logic [1:0] trap_cause;

  modport master (
    input  run, opcode, funct3, alu_zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write,
    output pc_write, reg_write, alu_src_a, alu_src_b,
    output result_src, is_branch, is_alu_reg, is_alu_imm,
    output busy, trap, trap_cause
  );

  modport slave (
    output run, opcode, funct3, alu_zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write,
    input  pc_write, reg_write, alu_src_a, alu_src_b,
    input  result_src, is_branch, is_alu_reg, is_alu_imm,
    input  busy, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch,
// decode, execute, memory and writeback over one memory port and ALU.
module multicycle_control #(
  parameter bit BOOT_WAIT = 1'b1,
  parameter int MAX_WAIT  = 15
) (
  input logic clk,
  input logic reset_n,
  multicycle_control_if.master bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_wait;
  logic [WW-1:0] w_wait_next;
  logic [1:0]    r_cause;
  logic [1:0]    w_cause_next;
  logic          w_mem_req;
  logic          w_timeout;

  assign w_mem_req = (r_state == S_FETCH)
                   | (r_state == S_MEMREAD)
                   | (r_state == S_MEMWRITE);

  // mem_ready in the last allowed cycle still completes the access
  assign w_timeout = w_mem_req & ~bus.mem_ready
                   & (r_wait == WW'(MAX_WAIT - 1));

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    unique case (r_state)
      S_IDLE:
        if (bus.run || !BOOT_WAIT) w_next = S_FETCH;
      S_FETCH:
        if (bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          7'b0000011,
          7'b0100011: w_next = S_MEMADR;
          7'b0110011: w_next = S_EXEC_R;
          7'b0010011: w_next = S_EXEC_I;
          7'b1100011: begin
            if (bus.funct3[2:1] == 2'b01) begin
              w_next       = S_TRAP;
              w_cause_next = 2'd2;
            end else begin
              w_next = S_BRANCH;
            end
          end
          7'b1101111: w_next = S_JAL;
          default: begin
            w_next       = S_TRAP;
            w_cause_next = 2'd1;
          end
        endcase
      end
      S_MEMADR:
        w_next = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:
        if (bus.mem_ready) w_next = S_MEMWB;
      S_MEMWRITE:
        if (bus.mem_ready) w_next = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:
        w_next = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_JAL:
        w_next = S_FETCH;
      S_TRAP:
        w_next = S_TRAP;
      default:
        w_next = S_IDLE;
    endcase
    if (w_timeout) begin
      w_next       = S_TRAP;
      w_cause_next = 2'd3;
    end
  end

  always_comb begin
    w_wait_next = r_wait + WW'(1);
    if (w_next != r_state || bus.mem_ready || !w_mem_req)
      w_wait_next = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_cause <= 2'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      r_cause <= w_cause_next;
    end
  end

  always_comb begin
    bus.mem_req    = w_mem_req;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'd0;
    bus.alu_src_b  = 2'd0;
    bus.result_src = 2'd0;
    bus.is_branch  = 1'b0;
    bus.is_alu_reg = 1'b0;
    bus.is_alu_imm = 1'b0;
    bus.busy       = (r_state != S_IDLE) && (r_state != S_TRAP);
    bus.trap       = (r_state == S_TRAP);
    bus.trap_cause = r_cause;
    unique case (r_state)
      S_FETCH: begin
        bus.alu_src_b  = 2'd2;
        bus.result_src = 2'd2;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_a = 2'd1;
        bus.alu_src_b = 2'd1;
      end
      S_MEMADR: begin
        bus.alu_src_a = 2'd2;
        bus.alu_src_b = 2'd1;
      end
      S_MEMREAD:
        bus.adr_src = 1'b1;
      S_MEMWB: begin
        bus.result_src = 2'd1;
        bus.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        bus.alu_src_a  = 2'd2;
        bus.is_alu_reg = 1'b1;
      end
      S_EXEC_I: begin
        bus.alu_src_a  = 2'd2;
        bus.alu_src_b  = 2'd1;
        bus.is_alu_imm = 1'b1;
      end
      S_ALUWB:
        bus.reg_write = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a = 2'd2;
        bus.is_branch = 1'b1;
        bus.pc_write  = bus.alu_zero ^ bus.funct3[0]
                      ^ bus.funct3[2];
      end
      S_JAL: begin
        bus.alu_src_a = 2'd1;
        bus.alu_src_b = 2'd2;
        bus.reg_write = 1'b1;
        bus.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction phase
// model, latency/effect vector table and multi-cycle corner sequences.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control #(
    .BOOT_WAIT(1'b1),
    .MAX_WAIT (15)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic       br;
    logic       ar;
    logic       ai;
    logic       busy;
    logic       trap;
    logic [1:0] cause;
  } out_t;

  typedef enum {
    P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB,
    P_MEMWRITE, P_EXEC_R, P_EXEC_I, P_ALUWB, P_BRANCH, P_JAL, P_TRAP
  } phase_t;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    int          lat;
    int          pcw;
    int          regw;
    int          cause;
  } vec_t;

  int       n_chk  = 0;
  int       n_fail = 0;
  int       m_irw  = 0;
  logic [1:0] m_cause = 2'd0;
  bit       noise  = 1'b0;

  function automatic out_t dut_out();
    out_t o;
    o.mem_req   = bus.mem_req;
    o.mem_write = bus.mem_write;
    o.adr_src   = bus.adr_src;
    o.ir_write  = bus.ir_write;
    o.pc_write  = bus.pc_write;
    o.reg_write = bus.reg_write;
    o.a         = bus.alu_src_a;
    o.b         = bus.alu_src_b;
    o.rs        = bus.result_src;
    o.br        = bus.is_branch;
    o.ar        = bus.is_alu_reg;
    o.ai        = bus.is_alu_imm;
    o.busy      = bus.busy;
    o.trap      = bus.trap;
    o.cause     = bus.trap_cause;
    return o;
  endfunction

  // Expected output vector of each phase, straight from the phase table
  function automatic out_t exp_out(phase_t p, logic rdy, logic z,
                                   logic [2:0] f3, logic [1:0] c);
    out_t o;
    o = '0;
    case (p)
      P_FETCH: begin
        o.mem_req = 1; o.b = 2; o.rs = 2;
        o.ir_write = rdy; o.pc_write = rdy;
      end
      P_DECODE:   begin o.a = 1; o.b = 1; end
      P_MEMADR:   begin o.a = 2; o.b = 1; end
      P_MEMREAD:  begin o.mem_req = 1; o.adr_src = 1; end
      P_MEMWB:    begin o.rs = 1; o.reg_write = 1; end
      P_MEMWRITE: begin
        o.mem_req = 1; o.mem_write = 1; o.adr_src = 1;
      end
      P_EXEC_R:   begin o.a = 2; o.b = 0; o.ar = 1; end
      P_EXEC_I:   begin o.a = 2; o.b = 1; o.ai = 1; end
      P_ALUWB:    o.reg_write = 1;
      P_BRANCH: begin
        o.a = 2; o.br = 1; o.pc_write = z ^ f3[0] ^ f3[2];
      end
      P_JAL: begin
        o.a = 1; o.b = 2; o.reg_write = 1; o.pc_write = 1;
      end
      P_TRAP:     o.trap = 1;
      default: ;
    endcase
    o.busy  = !(p == P_IDLE || p == P_TRAP);
    o.cause = c;
    return o;
  endfunction

  task automatic check_out(input string nm, input out_t got,
                           input out_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got,
                           input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  function automatic logic nz();
    return noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic step(input phase_t p, input logic rdy,
                      input string nm);
    bus.mem_ready = rdy;
    @(negedge clk);
    if (bus.ir_write) m_irw++;
    check_out(nm, dut_out(),
              exp_out(p, rdy, bus.alu_zero, bus.funct3, m_cause));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.run       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 7'h00;
    bus.funct3    = 3'd0;
    bus.alu_zero  = 1'b0;
    m_cause       = 2'd0;
    @(posedge clk);
    #1;
    check_out("reset_hold", dut_out(), out_t'('0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    do_reset();
    bus.run = 1'b1;
    step(P_IDLE, nz(), "idle_run");
    bus.run = 1'b0;
  endtask

  // One instruction from FETCH back to FETCH (or into TRAP)
  task automatic run_instr(input logic [31:0] instr, input logic z,
                           input int fw, input int mw);
    logic [6:0] op;
    logic [2:0] f3;
    op = instr[6:0];
    f3 = instr[14:12];
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.alu_zero = z;
    for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, "fetch_wait");
    step(P_FETCH, 1'b1, "fetch");
    step(P_DECODE, nz(), "decode");
    if (op == 7'h03 || op == 7'h23) begin
      step(P_MEMADR, nz(), "memadr");
      if (op == 7'h03) begin
        for (int i = 0; i < mw; i++) step(P_MEMREAD, 1'b0, "mrd_wait");
        step(P_MEMREAD, 1'b1, "memread");
        step(P_MEMWB, nz(), "memwb");
      end else begin
        for (int i = 0; i < mw; i++) step(P_MEMWRITE, 1'b0, "mwr_wait");
        step(P_MEMWRITE, 1'b1, "memwrite");
      end
    end else if (op == 7'h33) begin
      step(P_EXEC_R, nz(), "exec_r");
      step(P_ALUWB, nz(), "aluwb_r");
    end else if (op == 7'h13) begin
      step(P_EXEC_I, nz(), "exec_i");
      step(P_ALUWB, nz(), "aluwb_i");
    end else if (op == 7'h6F) begin
      step(P_JAL, nz(), "jal");
    end else if (op == 7'h63 && f3[2:1] != 2'b01) begin
      step(P_BRANCH, nz(), "branch");
    end else begin
      m_cause = (op == 7'h63) ? 2'd2 : 2'd1;
      step(P_TRAP, 1'b0, "trap_enter");
      bus.run = 1'b1;
      step(P_TRAP, 1'b1, "trap_run_ignored");
      bus.run = 1'b0;
      step(P_TRAP, 1'b0, "trap_hold");
    end
  endtask

  vec_t tbl[12];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h00500093, 1'b0, 4, 0, 1, 0};
    tbl[1]  = '{32'h002081B3, 1'b0, 4, 0, 1, 0};
    tbl[2]  = '{32'h0000A103, 1'b0, 5, 0, 1, 0};
    tbl[3]  = '{32'h0020A023, 1'b0, 4, 0, 0, 0};
    tbl[4]  = '{32'h00000063, 1'b1, 3, 1, 0, 0};
    tbl[5]  = '{32'h00001063, 1'b1, 3, 0, 0, 0};
    tbl[6]  = '{32'h00004063, 1'b0, 3, 1, 0, 0};
    tbl[7]  = '{32'h00005063, 1'b0, 3, 0, 0, 0};
    tbl[8]  = '{32'h0000006F, 1'b0, 3, 1, 1, 0};
    tbl[9]  = '{32'h0000007F, 1'b0, 0, 0, 0, 1};
    tbl[10] = '{32'h00002063, 1'b0, 0, 0, 0, 2};
    tbl[11] = '{32'h00000037, 1'b0, 0, 0, 0, 1};

    // Reset state and IDLE hold without run
    do_reset();
    for (int i = 0; i < 3; i++) step(P_IDLE, 1'b1, "idle_hold");

    // addi, then lw with 3-cycle waits, then branches
    bus.run = 1'b1;
    step(P_IDLE, 1'b0, "idle_run");
    bus.run = 1'b0;
    run_instr(32'h00500093, 1'b0, 0, 0);
    m_irw = 0;
    run_instr(32'h0000A103, 1'b0, 3, 3);
    check_int("lw_ir_write_pulses", m_irw, 1);
    run_instr(32'h00000063, 1'b1, 0, 0);
    run_instr(32'h00001063, 1'b1, 0, 0);
    run_instr(32'h00004063, 1'b0, 0, 0);
    run_instr(32'h0000007F, 1'b0, 0, 0);

    // Fetch timeout after 15 idle memory cycles
    restart();
    bus.opcode = 7'h13;
    for (int i = 0; i < 15; i++) step(P_FETCH, 1'b0, "fetch_stall");
    m_cause = 2'd3;
    step(P_TRAP, 1'b0, "timeout_trap");
    bus.run = 1'b1;
    step(P_TRAP, 1'b0, "timeout_run_ignored");
    bus.run = 1'b0;

    // mem_ready in the 15th cycle still completes
    restart();
    run_instr(32'h00500093, 1'b0, 14, 0);
    run_instr(32'h0000A103, 1'b0, 0, 14);

    // Asynchronous reset in the middle of a store
    restart();
    bus.opcode = 7'h23;
    bus.funct3 = 3'b010;
    step(P_FETCH, 1'b1, "sw_fetch");
    step(P_DECODE, 1'b0, "sw_decode");
    step(P_MEMADR, 1'b0, "sw_memadr");
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_out("sw_memwrite", dut_out(),
              exp_out(P_MEMWRITE, 1'b0, 1'b0, 3'b010, 2'd0));
    #1 reset_n = 1'b0;
    #1;
    check_out("async_reset_drop", dut_out(), out_t'('0));
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(P_IDLE, 1'b0, "post_reset_idle");

    // Latency and side-effect table, zero-wait memory
    foreach (tbl[k]) begin
      int lat, pcw, regw;
      restart();
      bus.opcode    = tbl[k].instr[6:0];
      bus.funct3    = tbl[k].instr[14:12];
      bus.alu_zero  = tbl[k].zero;
      bus.mem_ready = 1'b1;
      lat = 0; pcw = 0; regw = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c > 0) begin
          if (bus.ir_write) begin
            lat = c;
            break;
          end
          if (bus.trap) break;
          pcw  += int'(bus.pc_write);
          regw += int'(bus.reg_write);
        end
        @(posedge clk);
        #1;
      end
      check_int($sformatf("tbl%0d_latency", k), lat, tbl[k].lat);
      check_int($sformatf("tbl%0d_pc_write", k), pcw, tbl[k].pcw);
      check_int($sformatf("tbl%0d_reg_write", k), regw, tbl[k].regw);
      check_int($sformatf("tbl%0d_trap_cause", k),
                int'(bus.trap_cause), tbl[k].cause);
    end

    // Random legal instruction stream with random memory waits
    restart();
    noise = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] r;
      logic [31:0] instr;
      logic [6:0]  op;
      logic [2:0]  f3;
      r  = $urandom;
      f3 = r[14:12];
      case ($urandom_range(0, 5))
        0: op = 7'h03;
        1: op = 7'h23;
        2: op = 7'h33;
        3: op = 7'h13;
        4: begin
          op = 7'h63;
          if (f3[2:1] == 2'b01) f3[1] = 1'b0;
        end
        default: op = 7'h6F;
      endcase
      instr = {r[31:15], f3, r[11:7], op};
      run_instr(instr, 1'($urandom_range(0, 1)),
                $urandom_range(0, 4), $urandom_range(0, 4));
    end
    noise = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core variant.
- Sequences fetch, decode, execute, memory and writeback over a shared memory port and a single ALU.
- Produces the class flags (is_branch, is_alu_reg, is_alu_imm) consumed by the existing ALU decoder, plus all datapath mux, enable and memory handshake controls.
- Sits between the instruction register, the ALU decoder and the datapath.

Parameters:
- BOOT_WAIT, 1, when 1 leave IDLE only on run=1; when 0 leave IDLE on the first cycle after reset release.
- MAX_WAIT, 15, memory wait-cycle limit before a bus_err trap; counter width is $clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- run  in  1  start request, sampled in IDLE
- opcode  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory handshake completion, valid the cycle it is high
- mem_req  out  1  memory access request
- mem_write  out  1  write strobe, qualified by mem_req
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load instruction register and oldPC
- pc_write  out  1  load PC
- reg_write  out  1  register file write enable
- alu_src_a  out  2  0 = PC, 1 = oldPC, 2 = rs1
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
- result_src  out  2  0 = ALU result register, 1 = mem data, 2 = ALU direct
- is_branch, is_alu_reg, is_alu_imm  out  1 each  ALU decoder class flags
- busy  out  1  high in every state except IDLE and TRAP
- trap  out  1  sticky illegal-instruction or bus-error flag
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = illegal branch funct3, 3 = memory timeout

Behaviour:
- Outputs are a combinational decode of the state register, gated by mem_ready where stated. An unlisted output is 0 in that state.
- Reset (reset_n=0, asynchronous) forces state IDLE, wait counter 0, trap=0, trap_cause=0. All outputs are 0 during and immediately after reset.
- IDLE:
  - Go to FETCH when run=1, or unconditionally when BOOT_WAIT=0.
  - run is ignored in every other state.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=2, result_src=2.
  - ir_write and pc_write are high only in the mem_ready cycle.
  - On mem_ready go to DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a=1, alu_src_b=1 (branch-target precompute).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH, but if funct3 is 010 or 011 -> TRAP with cause 2
    - 1101111 -> JAL
    - any other opcode -> TRAP with cause 1
- MEMADR:
  - Outputs: alu_src_a=2, alu_src_b=1.
  - Go to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD:
  - Outputs: mem_req=1, adr_src=1.
  - On mem_ready go to MEMWB.
- MEMWB: result_src=1, reg_write=1; then FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, mem_write=1, adr_src=1.
  - On mem_ready go to FETCH.
- EXEC_R: alu_src_a=2, alu_src_b=0, is_alu_reg=1; then ALUWB.
- EXEC_I: alu_src_a=2, alu_src_b=1, is_alu_imm=1; then ALUWB.
- ALUWB: result_src=0, reg_write=1; then FETCH.
- BRANCH:
  - Outputs: alu_src_a=2, alu_src_b=0, is_branch=1, result_src=0.
  - pc_write = alu_zero ^ funct3[0] ^ funct3[2].
  - Then FETCH.
- JAL:
  - Outputs: alu_src_a=1, alu_src_b=2, result_src=0, reg_write=1, pc_write=1.
  - Then FETCH.
- TRAP:
  - Absorbing; trap=1, busy=0.
  - Left only by reset; trap_cause is held.
- Wait counter:
  - Increments on each cycle mem_req=1 and mem_ready=0; clears on mem_ready or a state change.
  - If it reaches MAX_WAIT while mem_ready=0, go to TRAP with cause 3.
  - mem_ready wins if both occur in the same cycle.
- Latencies (from entering FETCH, zero-wait memory, counted to re-entering FETCH):
  - R/I/load-free ALU op: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jal: 3 cycles
- mem_ready while mem_req=0 is ignored.
- Reset asserted mid-access drops mem_req within the same cycle, asynchronously.

Test Plan:
- Reset, then run=1 for one cycle, then addi 0x00500093 with zero-wait memory -> states IDLE, FETCH, DECODE, EXEC_I, ALUWB, FETCH. is_alu_imm=1 only in EXEC_I; reg_write=1 only in ALUWB.
- lw 0x0000A103 with mem_ready delayed 3 cycles in both FETCH and MEMREAD -> ir_write pulses exactly once. MEMWB asserts result_src=1 and reg_write=1. No trap.
- beq 0x00000063 with alu_zero=1 -> pc_write=1 in BRANCH. bne (funct3=001) with alu_zero=1 -> pc_write=0. blt (funct3=100) with alu_zero=0 -> pc_write=1.
- Opcode 0x7F in DECODE -> TRAP, trap=1, trap_cause=1, busy=0. Further run pulses are ignored until reset_n=0.
- FETCH with mem_ready held low for 15 cycles -> TRAP, trap_cause=3. A second run with mem_ready arriving in cycle 15 -> proceeds to DECODE, no trap.
- Assert reset_n=0 mid-MEMWRITE -> mem_req and mem_write drop immediately. After release the FSM is in IDLE with all outputs 0.
